// File: rtl/fpu_pkg.sv
// Shared FP32 definitions for the FPU datapath (fmul_pipe, fdiv).
package fpu_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MANT_W = 23;
    localparam int          BIAS   = 127;

    localparam logic [31:0] FP_QNAN = 32'h7fc0_0000;
    localparam logic [31:0] FP_INF  = 32'h7f80_0000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fp32_t;

    typedef enum logic [1:0] {
        ZERO,
        NORM,
        INF,
        NAN
    } fp_class_t;

    // Denormals are treated as zero: only the exponent decides ZERO.
    function automatic fp_class_t fp_classify(input fp32_t f);
        fp_class_t c;
        if (f.exp == '0) begin
            c = ZERO;
        end else if (f.exp == '1) begin
            c = (f.mant == '0) ? INF : NAN;
        end else begin
            c = NORM;
        end
        return c;
    endfunction

endpackage

// File: rtl/mant_mul24.sv
// Registered 24x24 -> 48 unsigned mantissa multiplier.
module mant_mul24 (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] a,
    input  logic [23:0] b,
    output logic [47:0] p
);

    // Product register; cleared on reset so downstream never sees X.
    always_ff @(posedge clk) begin
        if (rst) begin
            p <= '0;
        end else begin
            p <= 48'(a) * 48'(b);
        end
    end

endmodule

// File: rtl/fmul_pipe.sv
// Three-stage pipelined FP32 multiplier, flush-to-zero, round-to-nearest-even.
module fmul_pipe
    import fpu_pkg::*;
#(
    parameter int LATENCY = 3,
    parameter int FTZ     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        out_valid,
    output logic [31:0] y
);

    if (LATENCY != 3) begin : g_bad_latency
        $error("fmul_pipe: only LATENCY=3 is supported");
    end
    if (FTZ != 1) begin : g_bad_ftz
        $error("fmul_pipe: only FTZ=1 is supported");
    end

    // ---------------- stage 1: unpack and classify ----------------
    fp32_t            op_a;
    fp32_t            op_b;
    logic signed [9:0] esum_c;

    assign op_a   = x1;
    assign op_b   = x2;
    assign esum_c = $signed({2'b00, op_a.exp}) + $signed({2'b00, op_b.exp})
                  - $signed(10'(BIAS));

    logic              s1_valid;
    logic              s1_sign;
    logic signed [9:0] s1_esum;
    fp_class_t         s1_cls_a;
    fp_class_t         s1_cls_b;
    logic [23:0]       s1_mant_a;
    logic [23:0]       s1_mant_b;

    // Stage 1 register: sign, biased exponent sum, operand classes, mantissas.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_esum   <= '0;
            s1_cls_a  <= ZERO;
            s1_cls_b  <= ZERO;
            s1_mant_a <= '0;
            s1_mant_b <= '0;
        end else begin
            s1_valid  <= in_valid;
            s1_sign   <= op_a.sign ^ op_b.sign;
            s1_esum   <= esum_c;
            s1_cls_a  <= fp_classify(op_a);
            s1_cls_b  <= fp_classify(op_b);
            s1_mant_a <= {1'b1, op_a.mant};
            s1_mant_b <= {1'b1, op_b.mant};
        end
    end

    // ---------------- stage 2: mantissa multiply ----------------
    logic [47:0]       s2_prod;
    logic              s2_valid;
    logic              s2_sign;
    logic signed [9:0] s2_esum;
    fp_class_t         s2_cls_a;
    fp_class_t         s2_cls_b;

    mant_mul24 u_mant_mul (
        .clk (clk),
        .rst (rst),
        .a   (s1_mant_a),
        .b   (s1_mant_b),
        .p   (s2_prod)
    );

    // Stage 2 register: side-band fields travelling next to the product.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_esum  <= '0;
            s2_cls_a <= ZERO;
            s2_cls_b <= ZERO;
        end else begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_esum  <= s1_esum;
            s2_cls_a <= s1_cls_a;
            s2_cls_b <= s1_cls_b;
        end
    end

    // ---------------- stage 3: normalise, round, pack ----------------
    logic              p47;
    logic [22:0]       mant_n;
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic              carry;
    logic [22:0]       mant_r;
    logic signed [9:0] exp_n;
    logic signed [9:0] exp_f;
    logic              any_nan;
    logic              any_inf;
    logic              any_zero;
    logic [31:0]       y_next;

    // Normalise, round to nearest even, then apply special-case priority.
    always_comb begin
        p47      = s2_prod[47];
        mant_n   = '0;
        guard    = 1'b0;
        sticky   = 1'b0;
        round_up = 1'b0;
        carry    = 1'b0;
        mant_r   = '0;
        exp_n    = '0;
        exp_f    = '0;
        y_next   = '0;

        if (p47) begin
            mant_n = s2_prod[46:24];
            guard  = s2_prod[23];
            sticky = |s2_prod[22:0];
        end else begin
            mant_n = s2_prod[45:23];
            guard  = s2_prod[22];
            sticky = |s2_prod[21:0];
        end
        exp_n = s2_esum + $signed({9'd0, p47});

        round_up        = guard & (sticky | mant_n[0]);
        {carry, mant_r} = {1'b0, mant_n} + {23'd0, round_up};
        exp_f           = exp_n + $signed({9'd0, carry});

        any_nan  = (s2_cls_a == NAN) || (s2_cls_b == NAN)
                || ((s2_cls_a == INF) && (s2_cls_b == ZERO))
                || ((s2_cls_a == ZERO) && (s2_cls_b == INF));
        any_inf  = (s2_cls_a == INF) || (s2_cls_b == INF);
        any_zero = (s2_cls_a == ZERO) || (s2_cls_b == ZERO);

        if (any_nan) begin
            y_next = FP_QNAN;
        end else if (any_inf) begin
            y_next = {s2_sign, FP_INF[30:0]};
        end else if (any_zero) begin
            y_next = {s2_sign, 31'd0};
        end else if (exp_f >= 10'sd255) begin
            y_next = {s2_sign, FP_INF[30:0]};
        end else if (exp_f <= 10'sd0) begin
            y_next = {s2_sign, 31'd0};
        end else begin
            y_next = {s2_sign, exp_f[7:0], mant_r};
        end
    end

    // Output register: result and its valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
        end else begin
            out_valid <= s2_valid;
            y         <= y_next;
        end
    end

endmodule

// File: tb/tb_fmul_pipe.sv
// Self-checking bench for fmul_pipe: behavioural model plus latency scoreboard.
module tb_fmul_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] x1 = '0;
    logic [31:0] x2 = '0;
    logic        out_valid;
    logic [31:0] y;

    always #5 clk = ~clk;

    fmul_pipe #(.LATENCY(3), .FTZ(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .x1        (x1),
        .x2        (x2),
        .out_valid (out_valid),
        .y         (y)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, req, $time);
        end
    endtask

    // Reference product from the number itself: exact integer product,
    // rounded to 24 significant bits by remainder comparison.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        int                ea, eb, e, msb, sh;
        logic              s;
        longint unsigned   ma, mb, p, q, rem, half;
        bit                a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        a_nan  = (ea == 255) && (a[22:0] != 0);
        b_nan  = (eb == 255) && (b[22:0] != 0);
        a_inf  = (ea == 255) && (a[22:0] == 0);
        b_inf  = (eb == 255) && (b[22:0] == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return 32'h7fc00000;
        if (a_inf || b_inf) return {s, 8'hff, 23'd0};
        if (a_zero || b_zero) return {s, 31'd0};
        ma   = 64'h800000 + 64'(a[22:0]);
        mb   = 64'h800000 + 64'(b[22:0]);
        p    = ma * mb;
        msb  = (p >= (64'd1 << 47)) ? 47 : 46;
        sh   = msb - 23;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        e = ea + eb - 127 + (msb - 46);
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hff, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, 8'(e), q[22:0]};
    endfunction

    // Scoreboard: expected result and the cycle it must be visible.
    typedef struct {
        int          due;
        logic [31:0] val;
    } exp_t;

    exp_t q_exp[$];
    int   cyc    = 0;
    bit   chk_en = 1'b0;

    // Record every accepted operation; reset discards everything in flight.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            q_exp.delete();
        end else if (in_valid) begin
            q_exp.push_back('{cyc + 2, ref_mul(x1, x2)});
        end
    end

    // Compare DUT outputs with the scoreboard on every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("y_known", 32'($isunknown(y)), 32'd0);
            if (q_exp.size() > 0 && q_exp[0].due == cyc) begin
                check("sb_valid", 32'(out_valid), 32'd1);
                check("sb_y", y, q_exp[0].val);
                void'(q_exp.pop_front());
            end else begin
                check("sb_idle_valid", 32'(out_valid), 32'd0);
            end
        end
    end

    // Directed vectors: operands and hand-computed products.
    logic [31:0] vec_a [13] = '{32'h40400000, 32'h437f0000, 32'h3fc00000, 32'h3f800000,
                                32'h7f000000, 32'h00800000, 32'h80800000, 32'h7f800000,
                                32'hff800000, 32'h7fc00001, 32'h00000001, 32'h3f800001,
                                32'h3fffffff};
    logic [31:0] vec_b [13] = '{32'h40000000, 32'hc37f0000, 32'h3fc00000, 32'h3f8ccccd,
                                32'h40000000, 32'h3f000000, 32'h3f000000, 32'h00000000,
                                32'h40000000, 32'h3f800000, 32'h40000000, 32'h3f800001,
                                32'h3fffffff};
    logic [31:0] vec_y [13] = '{32'h40c00000, 32'hc77e0100, 32'h40100000, 32'h3f8ccccd,
                                32'h7f800000, 32'h00000000, 32'h80000000, 32'h7fc00000,
                                32'hff800000, 32'h7fc00000, 32'h00000000, 32'h3f800002,
                                32'h407ffffe};

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 4))
            0: ;
            1: r[30:23] = 8'($urandom_range(0, 3));
            2: r[30:23] = 8'($urandom_range(251, 255));
            3: r[30:23] = 8'($urandom_range(100, 154));
            default: begin
                case ($urandom_range(0, 4))
                    0: r[30:0] = 31'h0;
                    1: r[30:0] = 31'h7f800000;
                    2: r[30:0] = 31'h7fc00000;
                    3: r[30:0] = 31'h3f800000;
                    default: r[30:0] = 31'($urandom_range(1, 32'h7fffff));
                endcase
            end
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state.
        rst = 1'b1;
        tick();
        tick();
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_y", y, 32'h0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Pin the model against hand-computed products.
        for (int i = 0; i < 13; i++) begin
            check($sformatf("model_vec%0d", i), ref_mul(vec_a[i], vec_b[i]), vec_y[i]);
        end

        // Single pulse: 3 * 2, result visible exactly three cycles later for one cycle.
        tick();
        in_valid = 1'b1;
        x1 = 32'h40400000;
        x2 = 32'h40000000;
        tick();
        in_valid = 1'b0;
        x1 = '0;
        x2 = '0;
        tick();
        check("lat_early", 32'(out_valid), 32'd0);
        tick();
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_y", y, 32'h40c00000);
        tick();
        check("lat_pulse_end", 32'(out_valid), 32'd0);
        repeat (3) tick();

        // All directed vectors back-to-back.
        in_valid = 1'b1;
        for (int i = 0; i < 13; i++) begin
            x1 = vec_a[i];
            x2 = vec_b[i];
            tick();
        end
        in_valid = 1'b0;
        repeat (5) tick();

        // Reset with two operations in flight.
        in_valid = 1'b1;
        x1 = 32'h40400000;
        x2 = 32'h40400000;
        tick();
        x1 = 32'h40000000;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("flush_valid%0d", i), 32'(out_valid), 32'd0);
            tick();
        end
        in_valid = 1'b1;
        x1 = 32'h3fc00000;
        x2 = 32'h40800000;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_y", y, 32'h40c00000);
        repeat (3) tick();

        // Randomised traffic with bubbles and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            x1 = rand_op();
            x2 = rand_op();
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b0;
        repeat (6) tick();
        check("sb_drained", 32'(q_exp.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
